divider: RTL and testbench

Sequential scaling divider for the histogram-equalization datapath. It takes one 8-bit cumulative-distribution value (cdf_in) and computes the equalized grey level g_out = min(255, floor(cdf_in * SCALE / DIVISOR)). The core is a radix-2 restoring division. It sits between the CDF accumulator and the pixel-mapping LUT writer. One operation is in flight at a time, and each result is flagged by a one-cycle ready pulse.

---
 rtl/divider_if.sv | 11 +
 rtl/divider.sv | 82 ++++++++
 tb/tb_divider.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake bundle between the CDF accumulator and the scaling divider.
// The master side issues start strobes; the slave side returns the grey level.
interface divider_if;
   logic       enable;
   logic [7:0] cdf_in;
   logic [7:0] g_out;
   logic       ready_g_out;

   modport master (output enable, output cdf_in, input g_out, input ready_g_out);
   modport slave  (input enable, input cdf_in, output g_out, output ready_g_out);
endinterface

// File: rtl/divider.sv
// Sequential scaling divider: g_out = min(255, floor(cdf_in * SCALE / DIVISOR)).
// One restoring radix-2 step per cycle, 16 BUSY cycles per result.
module divider #(
   parameter int unsigned SCALE   = 255,
   parameter int unsigned DIVISOR = 64
) (
   input  logic      clk,
   input  logic      reset,
   divider_if.slave  bus
);
   localparam logic [15:0] SCALE_W = 16'(SCALE);
   localparam logic [16:0] DIV_W   = 17'(DIVISOR);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_next;
   logic [15:0] dividend;
   logic [16:0] remainder;
   logic [15:0] quotient;
   logic [3:0]  count;

   logic        start, step, last;
   logic [16:0] r_shift, rem_next;
   logic [15:0] quo_next;
   logic        fits;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.enable) state_next = BUSY;
         BUSY: if (count == 4'd0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      start = (state == IDLE) && bus.enable;
      step  = (state == BUSY);
      last  = step && (count == 4'd0);
   end

   // Remainder stays below DIVISOR, so dropping its top bit before the shift loses nothing.
   always_comb begin
      r_shift  = 17'({remainder, dividend[count]});
      fits     = (r_shift >= DIV_W);
      rem_next = fits ? (r_shift - DIV_W) : r_shift;
      quo_next = quotient;
      quo_next[count] = fits;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dividend        <= '0;
         remainder       <= '0;
         quotient        <= '0;
         count           <= '0;
         bus.g_out       <= '0;
         bus.ready_g_out <= 1'b0;
      end else begin
         bus.ready_g_out <= 1'b0;
         if (start) begin
            dividend  <= 16'(bus.cdf_in) * SCALE_W;
            remainder <= '0;
            quotient  <= '0;
            count     <= 4'd15;
         end else if (step) begin
            remainder <= rem_next;
            quotient  <= quo_next;
            count     <= count - 4'd1;
            if (last) begin
               bus.g_out       <= (quo_next[15:8] != 8'd0) ? 8'hFF : quo_next[7:0];
               bus.ready_g_out <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_divider.sv
// Directed testbench for divider (SCALE=255, DIVISOR=64) with hand-computed results.
module tb_divider;
   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   divider_if bus ();

   divider #(.SCALE(255), .DIVISOR(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Single operation: ready must stay low for 15 edges, pulse on the 16th, then drop.
   task automatic run_op(input logic [7:0] cdf, input logic [7:0] exp);
      int pulses;
      bus.enable = 1'b1;
      bus.cdf_in = cdf;
      tick();
      bus.enable = 1'b0;
      bus.cdf_in = 8'($urandom_range(0, 255));
      pulses = 0;
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus.ready_g_out !== 1'b0) pulses++;
      end
      check("early_ready", 16'(pulses), 16'd0);
      tick();
      check("ready_pulse", 16'(bus.ready_g_out), 16'd1);
      check("g_out", 16'(bus.g_out), 16'(exp));
      tick();
      check("ready_drop", 16'(bus.ready_g_out), 16'd0);
      check("g_out_hold", 16'(bus.g_out), 16'(exp));
   endtask

   initial begin
      int pulses;
      int first_k;
      int second_k;
      logic [7:0] first_g;
      logic [7:0] second_g;

      bus.enable = 1'b0;
      bus.cdf_in = 8'd0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_g_out", 16'(bus.g_out), 16'd0);
      check("reset_ready", 16'(bus.ready_g_out), 16'd0);

      run_op(8'd4, 8'd15);
      run_op(8'd0, 8'd0);
      run_op(8'd16, 8'd63);
      run_op(8'd64, 8'd255);
      run_op(8'd255, 8'd255);

      // Request during BUSY is dropped
      bus.enable = 1'b1;
      bus.cdf_in = 8'd4;
      tick();
      bus.enable = 1'b0;
      pulses = 0;
      first_k = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            bus.enable = 1'b1;
            bus.cdf_in = 8'd200;
         end
         tick();
         bus.enable = 1'b0;
         if (bus.ready_g_out === 1'b1) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
      end
      check("busy_drop_pulses", 16'(pulses), 16'd1);
      check("busy_drop_latency", 16'(first_k), 16'd16);
      check("busy_drop_g_out", 16'(bus.g_out), 16'd15);

      // Reset aborts an operation in flight
      bus.enable = 1'b1;
      bus.cdf_in = 8'd16;
      tick();
      bus.enable = 1'b0;
      for (int k = 1; k < 8; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_g_out", 16'(bus.g_out), 16'd0);
      check("abort_ready", 16'(bus.ready_g_out), 16'd0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.ready_g_out !== 1'b0) pulses++;
      end
      check("abort_no_pulse", 16'(pulses), 16'd0);
      check("abort_g_out_hold", 16'(bus.g_out), 16'd0);
      run_op(8'd32, 8'd127);

      // Enable held high: back-to-back every 17 cycles
      bus.enable = 1'b1;
      bus.cdf_in = 8'd4;
      tick();
      bus.cdf_in = 8'd16;
      pulses = 0;
      first_k = -1;
      second_k = -1;
      first_g = 8'd0;
      second_g = 8'd0;
      for (int k = 1; k <= 33; k++) begin
         tick();
         if (bus.ready_g_out === 1'b1) begin
            pulses++;
            if (first_k < 0) begin
               first_k = k;
               first_g = bus.g_out;
            end else if (second_k < 0) begin
               second_k = k;
               second_g = bus.g_out;
            end
         end
      end
      bus.enable = 1'b0;
      check("stream_pulses", 16'(pulses), 16'd2);
      check("stream_first_k", 16'(first_k), 16'd16);
      check("stream_first_g", 16'(first_g), 16'd15);
      check("stream_second_k", 16'(second_k), 16'd33);
      check("stream_second_g", 16'(second_g), 16'd63);
      for (int k = 0; k < 20; k++) tick();
      check("stream_tail_ready", 16'(bus.ready_g_out), 16'd0);
      check("stream_tail_g_out", 16'(bus.g_out), 16'd63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
